pc_exc_unit: RTL and testbench
==============================

Name: pc_exc_unit

Overview:
Parametrised program-counter register with a vectored exception and interrupt front end for the multi-cycle CPU. It holds the PC, and applies the per-cycle PC write enable from the controller. It prioritises N synchronous exception sources plus one external interrupt, captures the return address (EPC) and cause, and supports return-from-exception. Kernel/user mode is encoded in PC[W-1], and user code cannot set that bit by jumping.

Parameters:
W, 32, PC width in bits (>= 8)
NEXC, 2, number of synchronous exception sources (1..14)
VEC_BASE, 32'h80000000, reset vector; all other vectors are offsets from this address
CW (localparam), $clog2(NEXC+2), width of the cause field

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
pc_we  input  1  PC write enable from controller; high only at instruction boundary / PC update cycle
pc_next  input  W  candidate next PC (PC+4, branch or jump target)
exc_req  input  NEXC  synchronous exception requests, level, bit 0 highest priority (bit 0 = illop, bit 1 = xadr at default)
irq  input  1  external interrupt request, level-sensitive
eret  input  1  return from exception, qualified by pc_we
pc  output  W  current PC
epc  output  W  saved return address
cause  output  CW  code of last exception taken
kernel  output  1  equals pc[W-1]
exc_taken  output  1  one-cycle pulse, registered

Behaviour:
- Reset is asynchronous. While reset is asserted: pc=VEC_BASE, epc=0, cause=0, exc_taken=0, so kernel=1. Reset asserted mid-operation overrides everything immediately, with no wait for clk.
- Vectors: exception i (bit index) goes to VEC_BASE+4*(i+1); irq goes to VEC_BASE+4*(NEXC+1). At the defaults these are illop 0x80000004, xadr 0x80000008, irq 0x8000000C. Address arithmetic is modulo 2^W.
- Per rising edge, exactly one action is taken, in strict priority order:
  1. Any exc_req bit set, taken regardless of pc_we:
     - pc <= vector of the lowest set index.
     - cause <= index+1.
     - epc <= pc (address of the faulting instruction), but only if kernel=0. If kernel=1, epc is held to preserve the original return address; cause still updates.
     - exc_taken <= 1.
  2. irq=1 and kernel=0 and pc_we=1:
     - pc <= irq vector.
     - cause <= NEXC+1.
     - epc <= pc_next (the resume address).
     - exc_taken <= 1.
     - irq is ignored when pc_we=0, and masked entirely while kernel=1.
  3. eret=1 and pc_we=1: pc <= epc. epc and cause are unchanged. eret is ignored when pc_we=0.
  4. pc_we=1: pc <= {pc_next[W-1] & kernel, pc_next[W-2:0]}. User mode cannot enter kernel space; the MSB is silently cleared. Kernel mode may write any value.
  5. Otherwise pc holds.
- exc_taken is 0 in every cycle except the one following a priority-1 or priority-2 action.
- Latency: a request present at edge k changes pc after edge k, visible in cycle k+1. There are no combinational paths from inputs to outputs.
- eret while kernel=1 with epc[W-1]=1 is legal: the core stays in kernel mode.
- epc and cause hold their value across all non-exception updates.

Optional Feature:
IRQ_SYNC_EN:
- Defined: irq passes through a two-flop synchronizer (both flops reset to 0) before the priority logic. This adds 2 cycles of irq latency.
- Undefined: irq feeds the priority logic directly and must be synchronous to clk.
- All other behaviour is identical in both builds.

Test Plan:
1. Run to pc=0x00000040, then pulse reset between edges -> pc=0x80000000 immediately, epc=0, cause=0, kernel=1, exc_taken=0.
2. User mode, pc=0x00000010, exc_req=2'b11, pc_we=0 -> next cycle pc=0x80000004, cause=1, epc=0x00000010, exc_taken=1 for exactly one cycle.
3. User mode, pc_we=1, pc_next=0x80000020 -> pc=0x00000020, kernel=0. In kernel mode, the same stimulus gives pc=0x80000020.
4. User mode, pc=0x40, irq=1, pc_we=1, pc_next=0x44 -> pc=0x8000000C, cause=3, epc=0x44. Then eret=1, pc_we=1 -> pc=0x44, kernel=0.
5. irq held high while kernel=1 across several pc_we cycles -> no vectoring. After eret to user mode, the first pc_we=1 cycle vectors to 0x8000000C. With IRQ_SYNC_EN, a fresh irq assertion vectors 2 cycles later than without it.
6. Kernel mode, epc=0x10, exc_req=2'b10 -> pc=0x80000008, cause=2, epc stays 0x10.

Source files
------------

// File: rtl/pc_exc_unit.sv
// pc_exc_unit: program counter with a vectored exception/interrupt front end.
//
// Holds the PC, applies the controller's PC write enable, prioritises NEXC
// synchronous exception sources plus one external interrupt, records the
// return address (epc) and the cause code, and handles return-from-exception.
// Kernel mode is PC[W-1]. A user-mode PC write always clears that bit, so
// kernel space can only be entered through a vector.
//
// Optional build macro: IRQ_SYNC_EN
//   defined   : irq passes through a two-flop synchronizer first, which adds
//               two cycles of interrupt latency.
//   undefined : irq must already be synchronous to clk and is used directly.
//
// Reset is asynchronous and active-high. All outputs come straight from
// registers, so no input has a combinational path to an output.

module pc_exc_unit #(
  parameter int             W        = 32,
  parameter int             NEXC     = 2,
  parameter logic [W-1:0]   VEC_BASE = 32'h80000000,
  localparam int            CW       = $clog2(NEXC + 2)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_we,
  input  logic [W-1:0]    pc_next,
  input  logic [NEXC-1:0] exc_req,
  input  logic            irq,
  input  logic            eret,
  output logic [W-1:0]    pc,
  output logic [W-1:0]    epc,
  output logic [CW-1:0]   cause,
  output logic            kernel,
  output logic            exc_taken
);

  // The interrupt vector sits directly after the last exception vector.
  // Its cause code is one past the highest exception code.
  localparam logic [W-1:0]  IRQ_VEC   = VEC_BASE + W'(4 * (NEXC + 1));
  localparam logic [CW-1:0] IRQ_CAUSE = CW'(NEXC + 1);

  // Architectural state
  logic [W-1:0]  pc_q,  pc_d;
  logic [W-1:0]  epc_q, epc_d;
  logic [CW-1:0] cause_q, cause_d;
  logic          exc_taken_q, exc_taken_d;

  // Decoded exception request
  logic          exc_any;
  logic [W-1:0]  exc_vec;
  logic [CW-1:0] exc_cause;

  // Interrupt as seen by the priority logic
  logic          irq_eff;
  logic          kernel_mode;

  assign kernel_mode = pc_q[W-1];

`ifdef IRQ_SYNC_EN
  logic irq_meta_q;
  logic irq_sync_q;

  // Two-flop synchronizer that brings the external irq into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_meta_q <= 1'b0;
      irq_sync_q <= 1'b0;
    end else begin
      irq_meta_q <= irq;
      irq_sync_q <= irq_meta_q;
    end
  end

  assign irq_eff = irq_sync_q;
`else
  assign irq_eff = irq;
`endif

  // Priority encoder over the exception requests: the lowest set index wins.
  // The loop runs downward so the lowest index is the last one assigned.
  always_comb begin
    exc_any   = 1'b0;
    exc_vec   = VEC_BASE;
    exc_cause = '0;
    for (int i = NEXC - 1; i >= 0; i--) begin
      if (exc_req[i]) begin
        exc_any   = 1'b1;
        exc_vec   = VEC_BASE + W'(4 * (i + 1));
        exc_cause = CW'(i + 1);
      end
    end
  end

  // Next-state selection, in strict priority order:
  // exception, interrupt, eret, PC write, hold
  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    exc_taken_d = 1'b0;

    if (exc_any) begin
      // A synchronous fault is taken whether or not pc_we is high.
      // A nested fault taken in kernel mode keeps the original return
      // address, but still reports the new cause.
      pc_d        = exc_vec;
      cause_d     = exc_cause;
      exc_taken_d = 1'b1;
      if (!kernel_mode) begin
        epc_d = pc_q;
      end
    end else if (irq_eff && !kernel_mode && pc_we) begin
      // Interrupts are taken only at an instruction boundary. They resume
      // at the instruction that would have executed next.
      pc_d        = IRQ_VEC;
      cause_d     = IRQ_CAUSE;
      epc_d       = pc_next;
      exc_taken_d = 1'b1;
    end else if (eret && pc_we) begin
      pc_d = epc_q;
    end else if (pc_we) begin
      // User code cannot set the kernel bit by jumping.
      pc_d = {pc_next[W-1] & kernel_mode, pc_next[W-2:0]};
    end
  end

  // State registers; reset takes effect immediately, without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= VEC_BASE;
      epc_q       <= '0;
      cause_q     <= '0;
      exc_taken_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      exc_taken_q <= exc_taken_d;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign kernel    = pc_q[W-1];
  assign exc_taken = exc_taken_q;

endmodule

// File: tb/tb_pc_exc_unit.sv
// Directed testbench for pc_exc_unit at the default parameters.
// The expected values are worked out by hand.
// If IRQ_SYNC_EN is defined, every irq scenario allows for two extra cycles.

module tb_pc_exc_unit;

`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk;
  logic        reset;
  logic        pc_we;
  logic [31:0] pc_next;
  logic [1:0]  exc_req;
  logic        irq;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        kernel;
  logic        exc_taken;

  int n_vec;
  int n_bad;
  logic [31:0] epc_exp;

  pc_exc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc_we     (pc_we),
    .pc_next   (pc_next),
    .exc_req   (exc_req),
    .irq       (irq),
    .eret      (eret),
    .pc        (pc),
    .epc       (epc),
    .cause     (cause),
    .kernel    (kernel),
    .exc_taken (exc_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic we, input logic [31:0] nxt, input logic [1:0] ex,
                        input logic ir, input logic er);
    pc_we   = we;
    pc_next = nxt;
    exc_req = ex;
    irq     = ir;
    eret    = er;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    set_in(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #2;
    check("rst_pc",        pc,               32'h80000000);
    check("rst_epc",       epc,              32'h0);
    check("rst_cause",     32'(cause),       32'h0);
    check("rst_kernel",    32'(kernel),      32'h1);
    check("rst_exc_taken", 32'(exc_taken),   32'h0);
    tick();
    check("rst_hold_pc",   pc,               32'h80000000);
    #2 reset = 1'b0;
    tick();

    // Kernel mode may write any PC, including the kernel bit
    set_in(1'b1, 32'h80000020, 2'b00, 1'b0, 1'b0);
    tick();
    check("kwrite_pc", pc, 32'h80000020);

    // Drop into user mode
    set_in(1'b1, 32'h00000010, 2'b00, 1'b0, 1'b0);
    tick();
    check("enter_user_pc",     pc,          32'h00000010);
    check("enter_user_kernel", 32'(kernel), 32'h0);

    // Both exceptions in user mode with pc_we low: illop (bit 0) wins
    set_in(1'b0, 32'h0, 2'b11, 1'b0, 1'b0);
    tick();
    check("exc_pc",        pc,             32'h80000004);
    check("exc_cause",     32'(cause),     32'h1);
    check("exc_epc",       epc,            32'h00000010);
    check("exc_taken_1",   32'(exc_taken), 32'h1);
    set_in(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    tick();
    check("exc_taken_0",   32'(exc_taken), 32'h0);
    check("exc_hold_pc",   pc,             32'h80000004);

    // eret with pc_we low is ignored
    set_in(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    tick();
    check("eret_nowe_pc", pc, 32'h80000004);

    // eret goes back to user mode
    set_in(1'b1, 32'h12345678, 2'b00, 1'b0, 1'b1);
    tick();
    check("eret_pc",     pc,          32'h00000010);
    check("eret_kernel", 32'(kernel), 32'h0);
    check("eret_epc",    epc,         32'h00000010);
    check("eret_cause",  32'(cause),  32'h1);

    // A user jump into kernel space has its MSB cleared
    set_in(1'b1, 32'h80000020, 2'b00, 1'b0, 1'b0);
    tick();
    check("ujump_pc",     pc,          32'h00000020);
    check("ujump_kernel", 32'(kernel), 32'h0);

    set_in(1'b1, 32'h00000040, 2'b00, 1'b0, 1'b0);
    tick();
    check("upc_40", pc, 32'h00000040);

    // Hold irq with pc_we low: no vectoring (this also covers the synchronizer fill)
    set_in(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    for (int s = 0; s < SYNC_LAT + 1; s++) tick();
    check("irq_nowe_pc", pc, 32'h00000040);

    // irq at an instruction boundary
    set_in(1'b1, 32'h00000044, 2'b00, 1'b1, 1'b0);
    tick();
    check("irq_pc",        pc,             32'h8000000C);
    check("irq_cause",     32'(cause),     32'h3);
    check("irq_epc",       epc,            32'h00000044);
    check("irq_exc_taken", 32'(exc_taken), 32'h1);

    // irq remains high but is masked in kernel mode
    for (int s = 0; s < 3; s++) begin
      set_in(1'b1, 32'h80000100 + 32'(4 * s), 2'b00, 1'b1, 1'b0);
      tick();
      check("irq_masked_pc", pc,             32'h80000100 + 32'(4 * s));
      check("irq_masked_et", 32'(exc_taken), 32'h0);
    end

    // eret to user mode while irq is still high
    set_in(1'b1, 32'h0, 2'b00, 1'b1, 1'b1);
    tick();
    check("eret2_pc", pc, 32'h00000044);
    // The first user-mode boundary vectors
    set_in(1'b1, 32'h00000048, 2'b00, 1'b1, 1'b0);
    tick();
    check("irq2_pc",  pc,  32'h8000000C);
    check("irq2_epc", epc, 32'h00000048);

    // Drop irq, return to user mode, then let any synchronizer drain
    set_in(1'b1, 32'h0, 2'b00, 1'b0, 1'b1);
    tick();
    check("eret3_pc", pc, 32'h00000048);
    set_in(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("drain_pc", pc, 32'h00000048);

    // Fresh irq latency: vectors at step SYNC_LAT, with pc_we high on every step
    for (int s = 0; s <= SYNC_LAT; s++) begin
      set_in(1'b1, 32'h00000100 + 32'(4 * s), 2'b00, 1'b1, 1'b0);
      tick();
      if (s < SYNC_LAT) check("irq_lat_wait_pc", pc, 32'h00000100 + 32'(4 * s));
      else              check("irq_lat_vec_pc",  pc, 32'h8000000C);
    end
    epc_exp = 32'h00000100 + 32'(4 * SYNC_LAT);
    check("irq_lat_epc", epc, epc_exp);

    // Exception taken in kernel mode: epc is preserved and cause is updated
    set_in(1'b0, 32'h0, 2'b10, 1'b0, 1'b0);
    tick();
    check("kexc_pc",    pc,         32'h80000008);
    check("kexc_cause", 32'(cause), 32'h2);
    check("kexc_epc",   epc,        epc_exp);

    // An exception outranks eret even when pc_we is high
    set_in(1'b1, 32'h0, 2'b01, 1'b0, 1'b1);
    tick();
    check("exc_vs_eret_pc",    pc,         32'h80000004);
    check("exc_vs_eret_cause", 32'(cause), 32'h1);

    // Run to user pc 0x40, then assert reset between clock edges
    set_in(1'b1, 32'h00000040, 2'b00, 1'b0, 1'b0);
    tick();
    check("pre_rst_pc", pc, 32'h00000040);
    #2 reset = 1'b1;
    #1;
    check("arst_pc",        pc,             32'h80000000);
    check("arst_epc",       epc,            32'h0);
    check("arst_cause",     32'(cause),     32'h0);
    check("arst_kernel",    32'(kernel),    32'h1);
    check("arst_exc_taken", 32'(exc_taken), 32'h0);
    #3 reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
